// File: rtl/handshake_test_producer.sv
// rtl/handshake_test_producer.sv - self-checking dav_/rfd operand producer for the dual-input multiplier
// Optional watchdog on every handshake wait: define HANDSHAKE_PRODUCER_TIMEOUT_EN.

module handshake_test_producer #(
    parameter int N_TESTS        = 60,
    parameter int SETUP_CYCLES   = 1,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rfd,
    output logic        dav_,
    output logic [7:0]  x,
    output logic [7:0]  y,
    input  logic        ok,
    input  logic [15:0] m,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_count,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_SETUP,
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [6:0]  N_LAST     = 7'(N_TESTS);
    localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);

    generate
        if (N_TESTS < 1 || N_TESTS > 64 || SETUP_CYCLES < 1 || HOLD_CYCLES < 1 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16383) begin : g_bad_param
            $error("handshake_test_producer: parameter out of range");
        end
    endgenerate

    function automatic logic [7:0] op_x(input logic [5:0] i);
        return ({4'd0, i[5:2]} + 8'd1) * 8'd5;
    endfunction

    function automatic logic [7:0] op_y(input logic [5:0] i);
        return ({6'd0, i[1:0]} + 8'd4) * 8'd7;
    endfunction

    function automatic logic [15:0] op_prod(input logic [5:0] i);
        return {8'd0, op_x(i)} * {8'd0, op_y(i)};
    endfunction

    state_t      state;
    logic [6:0]  send_idx;
    logic [6:0]  send_nxt;
    logic [6:0]  chk_idx;
    logic [15:0] cnt;
    logic        ok_q;
    logic        start_ok;
    logic        ok_hit;

    assign send_nxt = send_idx + 7'd1;
    assign start_ok = start && (state == S_IDLE || state == S_DONE);
    // Only a fresh rising edge of ok during a run, and only until every result is in, is scored.
    assign ok_hit   = ok && !ok_q && busy && (chk_idx != N_LAST);

`ifdef HANDSHAKE_PRODUCER_TIMEOUT_EN
    localparam logic [13:0] WD_LAST = 14'(TIMEOUT_CYCLES - 1);

    logic [13:0] wd_cnt;
    logic        wd_counting;
    logic        wd_clear;
    logic        wd_fire;
    logic        timeout_q;

    assign wd_counting = state inside {S_WAIT_RDY, S_ASSERT, S_RELEASE, S_DRAIN};
    // Counting states are entered from non-counting ones except RELEASE->DRAIN, which clears explicitly.
    assign wd_clear    = !wd_counting || ok_hit ||
                         (state == S_RELEASE && rfd && send_nxt == N_LAST);
    assign wd_fire     = wd_counting && !ok_hit && (wd_cnt == WD_LAST);
    assign timeout     = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt <= 14'd0;
        end else if (wd_clear) begin
            wd_cnt <= 14'd0;
        end else begin
            wd_cnt <= wd_cnt + 14'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            dav_     <= 1'b1;
            x        <= 8'd0;
            y        <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            send_idx <= 7'd0;
            cnt      <= 16'd0;
`ifdef HANDSHAKE_PRODUCER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef HANDSHAKE_PRODUCER_TIMEOUT_EN
            if (wd_fire) begin
                state     <= S_DONE;
                dav_      <= 1'b1;
                busy      <= 1'b0;
                done      <= 1'b1;
                timeout_q <= 1'b1;
            end else
`endif
            begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            send_idx <= 7'd0;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_WAIT_RDY;
`ifdef HANDSHAKE_PRODUCER_TIMEOUT_EN
                            timeout_q <= 1'b0;
`endif
                        end
                    end
                    S_WAIT_RDY: begin
                        if (rfd) begin
                            x     <= op_x(send_idx[5:0]);
                            y     <= op_y(send_idx[5:0]);
                            cnt   <= 16'd0;
                            state <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (cnt == SETUP_LAST) begin
                            cnt   <= 16'd0;
                            dav_  <= 1'b0;
                            state <= S_ASSERT;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_ASSERT: begin
                        if (!rfd) begin
                            cnt   <= 16'd0;
                            state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            dav_  <= 1'b1;
                            state <= S_RELEASE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    S_RELEASE: begin
                        // x/y stay put until the consumer re-arms rfd for the next pair.
                        if (rfd) begin
                            send_idx <= send_nxt;
                            if (send_nxt == N_LAST) begin
                                state <= S_DRAIN;
                            end else begin
                                x     <= op_x(send_nxt[5:0]);
                                y     <= op_y(send_nxt[5:0]);
                                cnt   <= 16'd0;
                                state <= S_SETUP;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (chk_idx == N_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ok_q      <= 1'b0;
            chk_idx   <= 7'd0;
            err_count <= 8'd0;
        end else begin
            ok_q <= ok;
            if (start_ok) begin
                chk_idx   <= 7'd0;
                err_count <= 8'd0;
            end else if (ok_hit) begin
                chk_idx <= chk_idx + 7'd1;
                if (m != op_prod(chk_idx[5:0]) && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_test_producer.sv
// tb/tb_handshake_test_producer.sv - randomized consumer and reference model for handshake_test_producer

module tb_handshake_test_producer;

    localparam int N = 60;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rfd   = 1'b0;
    logic        ok    = 1'b0;
    logic [15:0] m     = 16'd0;
    logic        dav_;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;
    logic        timeout;

    handshake_test_producer #(
        .N_TESTS       (N),
        .SETUP_CYCLES  (1),
        .HOLD_CYCLES   (3),
        .TIMEOUT_CYCLES(10000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rfd      (rfd),
        .dav_     (dav_),
        .x        (x),
        .y        (y),
        .ok       (ok),
        .m        (m),
        .busy     (busy),
        .done     (done),
        .err_count(err_count),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    int          tests   = 0;
    int          fails   = 0;
    int          pair_idx = 0;
    int          mdl_err = 0;
    bit          abort   = 1'b0;
    logic [15:0] last_m  = 16'd0;
    logic [7:0]  obs_x [N];
    logic [7:0]  obs_y [N];

    function automatic logic [7:0] mx(input int i);
        return 8'((i / 4 + 1) * 5);
    endfunction

    function automatic logic [7:0] my(input int i);
        return 8'((i % 4 + 4) * 7);
    endfunction

    function automatic logic [15:0] mp(input int i);
        return 16'(mx(i)) * 16'(my(i));
    endfunction

    function automatic int sat(input int e);
        return (e > 255) ? 255 : e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_dav(input logic lvl, input int limit);
        int n;
        n = 0;
        while (dav_ !== lvl && n < limit) begin
            step();
            n++;
        end
        if (dav_ !== lvl) begin
            tests++;
            fails++;
            $display("FAIL wait_dav: dav_=%b after %0d cycles, wanted %b", dav_, limit, lvl);
            abort = 1'b1;
        end
    endtask

    // Watches the pins every cycle: pairs appear in index order, x/y move only while dav_ is high
    // and only to the next pair, err_count tracks the consumer's own count of bad results.
    task automatic compare_loop();
        logic       pd;
        logic       prst;
        logic [7:0] px;
        logic [7:0] py;
        pd   = 1'b1;
        prst = 1'b1;
        px   = 8'd0;
        py   = 8'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pair_idx = 0;
                prst     = 1'b1;
            end else begin
                if (start && !busy) pair_idx = 0;
                if (!prst) begin
                    if (x !== px || y !== py) begin
                        check("xy_change_dav_high", {30'd0, pd, dav_}, 32'd3);
                        check("xy_change_next_pair", {16'd0, x, y}, {16'd0, mx(pair_idx), my(pair_idx)});
                    end
                    if (pd && !dav_) begin
                        check("pair_at_dav_fall", {16'd0, x, y}, {16'd0, mx(pair_idx), my(pair_idx)});
                        check("dav_fall_busy", {31'd0, busy}, 32'd1);
                        if (pair_idx < N) begin
                            obs_x[pair_idx] = x;
                            obs_y[pair_idx] = y;
                        end
                        pair_idx++;
                    end
                end
                check("busy_done_excl", {31'd0, busy & done}, 32'd0);
                check("err_count_track", {24'd0, err_count}, 32'(sat(mdl_err)));
                check("timeout_low", {31'd0, timeout}, 32'd0);
                prst = 1'b0;
            end
            pd = dav_;
            px = x;
            py = y;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start   = 1'b0;
        mdl_err = 0;
    endtask

    task automatic consume(input int mode);
        logic [7:0]  cx;
        logic [7:0]  cy;
        logic [15:0] mv;
        for (int k = 0; k < N && !abort; k++) begin
            rfd = 1'b1;
            wait_dav(1'b0, 100);
            if (abort) break;
            cx = x;
            cy = y;
            repeat ($urandom_range(0, 3)) step();
            rfd = 1'b0;
            wait_dav(1'b1, 100);
            if (abort) break;
            mv = 16'(cx) * 16'(cy);
            if ((mode == 1 && k == 0) || (mode == 2 && $urandom_range(0, 7) == 0)) mv = mv + 16'd1;
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 1) == 1) begin
                rfd = 1'b1;
                repeat ($urandom_range(0, 2)) step();
            end
            m  = mv;
            ok = 1'b1;
            step();
            ok = 1'b0;
            if (mv != mp(k)) mdl_err++;
            last_m = mv;
            rfd = 1'b1;
            step();
            if (k == 20) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
    endtask

    task automatic finish_run(input int exp_err);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        check("run_done", {31'd0, done}, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd0);
        check("run_dav", {31'd0, dav_}, 32'd1);
        check("run_err", {24'd0, err_count}, 32'(exp_err));
        check("run_pairs", 32'(pair_idx), 32'(N));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        fork
            compare_loop();
        join_none

        repeat (3) @(posedge clock);
        #1;
        check("rst_dav", {31'd0, dav_}, 32'd1);
        check("rst_x", {24'd0, x}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        step();

        // Start latency, long rfd-high stall, exact hold length, held release data.
        rfd = 1'b1;
        do_start();
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_dav_k", {31'd0, dav_}, 32'd1);
        step();
        check("lat_xy", {16'd0, x, y}, {16'd0, 8'd5, 8'd28});
        check("lat_dav_k1", {31'd0, dav_}, 32'd1);
        step();
        check("lat_dav_low", {31'd0, dav_}, 32'd0);
        repeat (50) begin
            step();
            check("stall_dav", {31'd0, dav_}, 32'd0);
            check("stall_xy", {16'd0, x, y}, {16'd0, 8'd5, 8'd28});
        end
        rfd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_low", {31'd0, dav_}, 32'd0);
        end
        step();
        check("hold_rise", {31'd0, dav_}, 32'd1);
        repeat (5) begin
            step();
            check("release_xy", {16'd0, x, y}, {16'd0, 8'd5, 8'd28});
            check("release_dav", {31'd0, dav_}, 32'd1);
        end
        rfd = 1'b1;
        step();
        check("pair1_xy", {16'd0, x, y}, {16'd0, 8'd5, 8'd35});
        check("pair1_setup_dav", {31'd0, dav_}, 32'd1);
        step();
        check("pair1_assert_dav", {31'd0, dav_}, 32'd0);

        // Asynchronous reset while dav_ is low.
        #2 reset = 1'b1;
        #1;
        check("arst_dav", {31'd0, dav_}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_xy", {16'd0, x, y}, 32'd0);
        step();
        reset = 1'b0;
        step();

        // Run 1: correct consumer.
        rfd = 1'b1;
        do_start();
        consume(0);
        finish_run(0);
        check("lit_pair0", {16'd0, obs_x[0], obs_y[0]}, {16'd0, 8'd5, 8'd28});
        check("lit_pair3", {16'd0, obs_x[3], obs_y[3]}, {16'd0, 8'd5, 8'd49});
        check("lit_pair4", {16'd0, obs_x[4], obs_y[4]}, {16'd0, 8'd10, 8'd28});
        check("lit_pair59", {16'd0, obs_x[59], obs_y[59]}, {16'd0, 8'd75, 8'd49});
        check("lit_last_m", {16'd0, last_m}, 32'd3675);

        // ok edge outside a run is ignored.
        m  = 16'h1234;
        ok = 1'b1;
        step();
        ok = 1'b0;
        repeat (2) step();
        check("idle_ok_err", {24'd0, err_count}, 32'd0);
        check("idle_ok_done", {31'd0, done}, 32'd1);

        // Run 2: only the first result is wrong (141 instead of 140).
        do_start();
        check("restart_done_clear", {31'd0, done}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        consume(1);
        finish_run(1);

        // Run 3: random corruption.
        do_start();
        check("restart_err_clear", {24'd0, err_count}, 32'd0);
        consume(2);
        finish_run(sat(mdl_err));

        // rfd stuck low after the first pair: the default build waits forever.
        rfd = 1'b1;
        do_start();
        wait_dav(1'b0, 50);
        rfd = 1'b0;
        repeat (200) step();
        check("stuck_busy", {31'd0, busy}, 32'd1);
        check("stuck_done", {31'd0, done}, 32'd0);
        check("stuck_timeout", {31'd0, timeout}, 32'd0);
        check("stuck_dav", {31'd0, dav_}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
